// File: rtl/metronome_beat_decoder.sv
// metronome_beat_decoder: listening end of the metronome audio link.
// Measures the period of a square-wave tone, classifies each beep as C# (beat)
// or G# (accent), counts beats 1..8 and shows the beat number on a 7-segment display.
//
// Ports:
//   clk          system clock (27 MHz nominal)
//   rst          synchronous active-high reset
//   tone_in      asynchronous square-wave audio input
//   a..g         7-segment drive, active-high, registered
//   beat_valid   one-cycle pulse when a beep is recognised
//   beat_tone    class of last recognised beep: 00 none, 01 C#, 10 G#
//   beat_num     current beat, 0 after reset, then 1..8
//   tone_active  high while a recognised beep is sounding
module metronome_beat_decoder #(
  parameter int unsigned C_SHARP_PERIOD = 97408,
  parameter int unsigned G_SHARP_PERIOD = 65014,
  parameter int unsigned PERIOD_TOL     = 2048,
  parameter int unsigned MIN_PERIODS    = 4,
  parameter int unsigned SILENCE_CYCLES = 1350000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tone_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       beat_valid,
  output logic [1:0] beat_tone,
  output logic [3:0] beat_num,
  output logic       tone_active
);

  localparam logic [1:0]  ClsNone    = 2'b00;
  localparam logic [1:0]  ClsCSharp  = 2'b01;
  localparam logic [1:0]  ClsGSharp  = 2'b10;
  localparam logic [16:0] PeriodSat  = '1;
  localparam logic [20:0] SilenceMax = 21'(SILENCE_CYCLES);
  localparam logic [7:0]  MatchGoal  = 8'(MIN_PERIODS);
  localparam int unsigned CSharpLo   = C_SHARP_PERIOD - PERIOD_TOL;
  localparam int unsigned CSharpHi   = C_SHARP_PERIOD + PERIOD_TOL;
  localparam int unsigned GSharpLo   = G_SHARP_PERIOD - PERIOD_TOL;
  localparam int unsigned GSharpHi   = G_SHARP_PERIOD + PERIOD_TOL;

  typedef enum logic [1:0] {StIdle, StAcquire, StTone} state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, sync3_q, edge_q;
  logic [16:0] period_q;
  logic [20:0] silence_q;
  logic [1:0]  cand_q, cand_d;
  logic [7:0]  match_q, match_d;
  logic [1:0]  beat_tone_q;
  logic [3:0]  beat_num_q;
  logic [6:0]  seg_q;
  logic [1:0]  period_cls;
  logic [31:0] period_ext;
  logic        silence_max;
  logic [3:0]  num_inc, num_next;

  function automatic logic [6:0] seg_encode(input logic [3:0] num);
    case (num)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      default: return 7'b0000000;
    endcase
  endfunction

  assign period_ext  = 32'(period_q);
  assign silence_max = (silence_q == SilenceMax);

  // Period is only meaningful on edge_q; a saturated count never matches.
  always_comb begin
    period_cls = ClsNone;
    if (period_q != PeriodSat) begin
      if (period_ext >= CSharpLo && period_ext <= CSharpHi) begin
        period_cls = ClsCSharp;
      end else if (period_ext >= GSharpLo && period_ext <= GSharpHi) begin
        period_cls = ClsGSharp;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    match_d    = match_q;
    beat_valid = 1'b0;
    case (state_q)
      StIdle: begin
        // First edge only starts the measurement; its partial period is dropped.
        if (edge_q) begin
          state_d = StAcquire;
          cand_d  = ClsNone;
          match_d = '0;
        end
      end
      StAcquire: begin
        if (edge_q) begin
          if (period_cls == ClsNone) begin
            cand_d  = ClsNone;
            match_d = '0;
          end else if (period_cls == cand_q) begin
            match_d = match_q + 8'd1;
          end else begin
            cand_d  = period_cls;
            match_d = 8'd1;
          end
          if (period_cls != ClsNone && match_d == MatchGoal) begin
            state_d    = StTone;
            beat_valid = 1'b1;
          end
        end else if (silence_max) begin
          state_d = StIdle;
        end
      end
      StTone: begin
        // Edges are ignored here; only silence ends the beep.
        if (!edge_q && silence_max) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Accent (G#) snaps the count to the end of the half-bar: 4 or 8.
  always_comb begin
    num_inc  = (beat_num_q >= 4'd8) ? 4'd1 : beat_num_q + 4'd1;
    num_next = num_inc;
    if (cand_d == ClsGSharp) begin
      num_next = (num_inc <= 4'd4) ? 4'd4 : 4'd8;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      edge_q      <= 1'b0;
      period_q    <= '0;
      silence_q   <= '0;
      state_q     <= StIdle;
      cand_q      <= ClsNone;
      match_q     <= '0;
      beat_tone_q <= ClsNone;
      beat_num_q  <= '0;
      seg_q       <= 7'b1111110;
    end else begin
      sync1_q <= tone_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q & ~sync3_q;

      if (edge_q) begin
        period_q <= 17'd1;
      end else if (period_q != PeriodSat) begin
        period_q <= period_q + 17'd1;
      end

      if (edge_q) begin
        silence_q <= '0;
      end else if (!silence_max) begin
        silence_q <= silence_q + 21'd1;
      end

      state_q <= state_d;
      cand_q  <= cand_d;
      match_q <= match_d;

      if (beat_valid) begin
        beat_tone_q <= cand_d;
        beat_num_q  <= num_next;
      end

      seg_q <= seg_encode(beat_num_q);
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;
  assign beat_tone   = beat_tone_q;
  assign beat_num    = beat_num_q;
  assign tone_active = (state_q == StTone);

endmodule

// File: tb/tb_metronome_beat_decoder.sv
// Bench for metronome_beat_decoder, run with shortened periods so a whole bar
// fits in a short simulation.
module tb_metronome_beat_decoder;

  localparam int CP   = 200;  // C# period
  localparam int GP   = 130;  // G# period
  localparam int TOL  = 8;
  localparam int MINP = 4;
  localparam int SIL  = 700;

  localparam logic [1:0] TC = 2'b01;
  localparam logic [1:0] TG = 2'b10;

  logic       clk = 1'b0;
  logic       rst;
  logic       tone_in;
  logic       a, b, c, d, e, f, g;
  logic       beat_valid;
  logic [1:0] beat_tone;
  logic [3:0] beat_num;
  logic       tone_active;
  logic [6:0] seg_now;

  metronome_beat_decoder #(
    .C_SHARP_PERIOD(CP),
    .G_SHARP_PERIOD(GP),
    .PERIOD_TOL    (TOL),
    .MIN_PERIODS   (MINP),
    .SILENCE_CYCLES(SIL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tone_in    (tone_in),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .e          (e),
    .f          (f),
    .g          (g),
    .beat_valid (beat_valid),
    .beat_tone  (beat_tone),
    .beat_num   (beat_num),
    .tone_active(tone_active)
  );

  always #5 clk = ~clk;
  assign seg_now = {a, b, c, d, e, f, g};

  typedef struct {
    int         period;
    int         edges;
    bit         exp_beat;
    logic [1:0] exp_tone;
  } vec_t;

  typedef struct {
    logic [1:0] tone;
    logic [3:0] num;
  } beat_t;

  beat_t      exp_q[$];
  vec_t       vecs[16];
  logic [6:0] seg_tab[16];
  int         checks, errors, cyc, last_rise, model_num;
  bit         st1, st2;
  logic [1:0] st1_tone;
  logic [3:0] st1_num, st2_num;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock, sample at the falling edge and run the scoreboard.
  task automatic tick();
    beat_t ent;
    @(negedge clk);
    cyc++;
    if (st2) begin
      chk("segments after beat", 32'(seg_now), 32'(seg_tab[st2_num]));
      st2 = 1'b0;
    end
    if (st1) begin
      chk("beat_tone", 32'(beat_tone), 32'(st1_tone));
      chk("beat_num", 32'(beat_num), 32'(st1_num));
      chk("tone_active on entry", 32'(tone_active), 32'd1);
      st2     = 1'b1;
      st2_num = st1_num;
      st1     = 1'b0;
    end
    if (beat_valid === 1'b1 && rst === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected beat_valid", 32'd1, 32'd0);
      end else begin
        ent = exp_q.pop_front();
        chk("beat_valid latency", 32'(cyc - last_rise), 32'd3);
        st1      = 1'b1;
        st1_tone = ent.tone;
        st1_num  = ent.num;
      end
    end
  endtask

  task automatic push_beat(input logic [1:0] tone);
    int n;
    n = (model_num >= 8) ? 1 : model_num + 1;
    if (tone == TG) n = (n <= 4) ? 4 : 8;
    model_num = n;
    exp_q.push_back('{tone, 4'(n)});
  endtask

  task automatic tone_cycle(input int period);
    tone_in   = 1'b1;
    last_rise = cyc;
    repeat (period / 2) tick();
    tone_in = 1'b0;
    repeat (period - period / 2) tick();
  endtask

  task automatic quiet(input int n);
    tone_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    tone_in = 1'b0;
    repeat (2) tick();
    rst       = 1'b0;
    model_num = 0;
    exp_q.delete();
    st1 = 1'b0;
    st2 = 1'b0;
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; cyc = 0; last_rise = 0; model_num = 0;
    st1 = 1'b0; st2 = 1'b0;
    st1_tone = '0; st1_num = '0; st2_num = '0;
    rst = 1'b1; tone_in = 1'b0;
    for (int i = 0; i < 16; i++) seg_tab[i] = 7'b0000000;
    seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000; seg_tab[2] = 7'b1101101;
    seg_tab[3] = 7'b1111001; seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
    seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000; seg_tab[8] = 7'b1111111;

    // G#-first resync, C#,C#,C#,G# bar twice, then tolerance edges.
    vecs[0]  = '{GP, 6, 1'b1, TG};
    vecs[1]  = '{CP, 6, 1'b1, TC};
    vecs[2]  = '{GP, 6, 1'b1, TG};
    vecs[3]  = '{CP, 6, 1'b1, TC};
    vecs[4]  = '{CP, 6, 1'b1, TC};
    vecs[5]  = '{CP, 6, 1'b1, TC};
    vecs[6]  = '{GP, 6, 1'b1, TG};
    vecs[7]  = '{CP, 6, 1'b1, TC};
    vecs[8]  = '{CP, 6, 1'b1, TC};
    vecs[9]  = '{CP, 6, 1'b1, TC};
    vecs[10] = '{GP, 6, 1'b1, TG};
    vecs[11] = '{CP + TOL, 6, 1'b1, TC};
    vecs[12] = '{CP + TOL + 1, 6, 1'b0, 2'b00};
    vecs[13] = '{GP + TOL, 6, 1'b1, TG};
    vecs[14] = '{GP - TOL - 1, 6, 1'b0, 2'b00};
    vecs[15] = '{CP - TOL, 6, 1'b1, TC};

    do_reset();
    chk("reset beat_valid", 32'(beat_valid), 32'd0);
    chk("reset beat_tone", 32'(beat_tone), 32'd0);
    chk("reset beat_num", 32'(beat_num), 32'd0);
    chk("reset tone_active", 32'(tone_active), 32'd0);
    chk("reset segments", 32'(seg_now), 32'(7'b1111110));

    // Single C# beep and its silence release.
    push_beat(TC);
    repeat (8) tone_cycle(CP);
    chk("tone_active during beep", 32'(tone_active), 32'd1);
    n = 0;
    while (tone_active === 1'b1 && n < SIL + 50) begin
      tick();
      n++;
    end
    chk("silence release window",
        32'((cyc - last_rise >= SIL) && (cyc - last_rise <= SIL + 8)), 32'd1);
    chk("single beep pending", 32'(exp_q.size()), 32'd0);
    chk("beat_num holds after beep", 32'(beat_num), 32'd1);
    chk("segments hold after beep", 32'(seg_now), 32'(7'b0110000));

    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].exp_beat) push_beat(vecs[i].exp_tone);
      repeat (vecs[i].edges) tone_cycle(vecs[i].period);
      quiet(SIL + 100);
      chk($sformatf("vec%0d pending", i), 32'(exp_q.size()), 32'd0);
      chk($sformatf("vec%0d tone_active idle", i), 32'(tone_active), 32'd0);
      chk($sformatf("vec%0d beat_num", i), 32'(beat_num), 32'(model_num));
    end

    // Alternating classes never build up enough matches.
    for (int i = 0; i < 5; i++) begin
      tone_cycle(CP);
      tone_cycle(GP);
    end
    tone_cycle(CP);
    chk("alternating no tone", 32'(tone_active), 32'd0);
    quiet(SIL + 100);
    chk("alternating beat_num", 32'(beat_num), 32'(model_num));

    // Short gap keeps one beep; long gap splits it into two.
    do_reset();
    push_beat(TC);
    repeat (6) tone_cycle(CP);
    quiet(SIL - 300);
    chk("short gap holds tone", 32'(tone_active), 32'd1);
    repeat (6) tone_cycle(CP);
    quiet(SIL + 100);
    chk("short gap pending", 32'(exp_q.size()), 32'd0);
    chk("short gap beat_num", 32'(beat_num), 32'd1);
    push_beat(TC);
    repeat (6) tone_cycle(CP);
    quiet(SIL + 200);
    chk("long gap releases", 32'(tone_active), 32'd0);
    push_beat(TC);
    repeat (6) tone_cycle(CP);
    quiet(SIL + 100);
    chk("long gap pending", 32'(exp_q.size()), 32'd0);
    chk("long gap beat_num", 32'(beat_num), 32'd3);

    // Reset in the middle of beat 6, tone carries on.
    do_reset();
    push_beat(TG);
    repeat (6) tone_cycle(GP);
    quiet(SIL + 100);
    push_beat(TC);
    repeat (6) tone_cycle(CP);
    quiet(SIL + 100);
    push_beat(TC);
    repeat (6) tone_cycle(CP);
    chk("pre-reset beat_num", 32'(beat_num), 32'd6);
    chk("pre-reset tone_active", 32'(tone_active), 32'd1);
    chk("pre-reset pending", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    tick();
    chk("mid-beep reset beat_num", 32'(beat_num), 32'd0);
    chk("mid-beep reset segments", 32'(seg_now), 32'(7'b1111110));
    chk("mid-beep reset tone_active", 32'(tone_active), 32'd0);
    rst       = 1'b0;
    model_num = 0;
    st1 = 1'b0;
    st2 = 1'b0;
    push_beat(TC);
    repeat (6) tone_cycle(CP);
    quiet(SIL + 100);
    chk("post-reset pending", 32'(exp_q.size()), 32'd0);
    chk("post-reset beat_num", 32'(beat_num), 32'd1);
    chk("post-reset segments", 32'(seg_now), 32'(7'b0110000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/metronome_beat_decoder.md
Name: metronome_beat_decoder

Overview:
- Listening end of the metronome audio interface. Samples a square-wave tone on one input pin at 27 MHz and measures its period.
- Classifies each beep as C# (beat tone) or G# (accent tone), counts beats 1–8 with accent resynchronisation, and drives a 7-segment display with the decoded beat number.
- Used to check a metronome output on a second board, or loop-back on the same board.

Parameters:
- C_SHARP_PERIOD, 97408, nominal C# period in clk cycles.
- G_SHARP_PERIOD, 65014, nominal G# period in clk cycles.
- PERIOD_TOL, 2048, allowed ± deviation for period classification (inclusive).
- MIN_PERIODS, 4, consecutive same-class periods needed to declare a beep.
- SILENCE_CYCLES, 1350000, cycles without a rising edge that end a beep (50 ms). Must be > 131071.

Ports:
- clk  in  1  27 MHz system clock
- rst  in  1  synchronous active-high reset
- tone_in  in  1  asynchronous square-wave audio input
- a, b, c, d, e, f, g  out  1 each  7-segment drive, active-high, registered
- beat_valid  out  1  one-cycle pulse when a beep is recognised
- beat_tone  out  2  class of last recognised beep: 00 none, 01 C#, 10 G#
- beat_num  out  4  current beat, 0 after reset, then 1..8
- tone_active  out  1  high while in TONE state

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. rst has priority over every other event in the same cycle.
- Reset values: beat_valid=0, beat_tone=00, beat_num=0, tone_active=0, segments=1111110 ("0"), FSM=IDLE, all counters 0.
- Input path: 2-FF synchroniser, then a registered rising-edge detect. An edge on tone_in is seen as edge_pulse 3 clk later.
- Period counter (17 bits):
  - On edge_pulse: capture the count as the period and reload to 1.
  - Otherwise increment, saturating at 131071.
- Silence counter (21 bits): cleared on edge_pulse, else increments, saturating at SILENCE_CYCLES.
- Classification of a captured period P:
  - C# if |P − C_SHARP_PERIOD| ≤ PERIOD_TOL.
  - G# if |P − G_SHARP_PERIOD| ≤ PERIOD_TOL.
  - Otherwise NONE. A saturated period is always NONE.
- FSM states:
  - IDLE:
    - First edge_pulse: clear the period counter, discard the partial period, go to ACQUIRE with cand=NONE, match=0.
  - ACQUIRE, on edge_pulse with class X:
    - X==cand and X≠NONE: match+1.
    - X≠NONE and X≠cand: cand=X, match=1.
    - X==NONE: cand=NONE, match=0.
    - When match reaches MIN_PERIODS: go to TONE in the same update.
  - TONE:
    - Entry: beat_valid=1 for exactly one cycle, beat_tone=cand, tone_active=1.
    - Further edges of any class are ignored; the beep is not retriggered.
  - Silence exit: in ACQUIRE or TONE, silence counter == SILENCE_CYCLES with no edge that cycle → IDLE, tone_active=0.
    - If an edge_pulse coincides with the threshold, the edge wins.
- Beat counting on each beat_valid:
  - C#: beat_num = beat_num+1, wrapping 8→1; 0→1.
  - G# (accent): beat_num = 4 if the incremented value ≤4, else 8. This resynchronises to the bar.
- Display: segments are registered from beat_num, one clk after beat_num changes.
  - Encoding abcdefg: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111.
  - Any other value → 0000000.
- Mid-beep reset: all state returns to reset values. A tone still present re-acquires from IDLE, discarding its first partial period.

Test Plan:
- C# square wave (period 97408) for 0.2 s after reset → beat_valid pulses once, 3 clk after the 5th rising edge; beat_tone=01, beat_num=1, segments 0110000 one clk later, tone_active falls 1350000 clk after the last edge.
- Metronome pattern C#,C#,C#,G# repeated twice, 1 s spacing → beat_num sequence 1,2,3,4,5,6,7,8; beat_tone 01,01,01,10,…; exactly 8 beat_valid pulses.
- G# as the first beep after reset → beat_num=4, segments 0110011. A following C# gives beat_num=5. A G# when beat_num=5 gives beat_num=8.
- Period 97408+2048 is accepted as C#; period 97408+2049 gives no beat_valid. Periods alternating C#/G# never reach 4 matches → no beat_valid, state stays ACQUIRE.
- C# tone with a 60 ms gap mid-beep → two beat_valid pulses. With a 40 ms gap → one pulse.
- rst asserted during TONE with beat_num=6 → next clk: beat_num=0, segments 1111110, tone_active=0. The tone continuing gives beat_valid after 5 further edges and beat_num=1.
